// File: rtl/pe_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pe_mem_arbiter
// Purpose  : Round-robin arbiter for NREQ PE loads onto a single memory read
//            port, with a bounded wait that ends in an error completion.
// Revision : 1.0
// ============================================================================
module pe_mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      pe_read,
    input  logic [NREQ*32-1:0]   pe_addr,
    output logic [NREQ-1:0]      pe_ack,
    output logic [31:0]          pe_rdata,
    output logic                 pe_err,
    output logic                 mem_read,
    output logic [31:0]          mem_address,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_Message,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [2:0]           grant_id_q, grant_id_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 mem_read_q, mem_read_d;
    logic [31:0]          mem_address_q, mem_address_d;
    logic [NREQ-1:0]      pe_ack_q, pe_ack_d;
    logic [31:0]          pe_rdata_q, pe_rdata_d;
    logic                 pe_err_q, pe_err_d;
    logic                 busy_q, busy_d;

    logic [2*NREQ-1:0]    w_dbl;
    logic [NREQ-1:0]      w_rot;
    logic [2:0]           w_off;
    logic [3:0]           w_sum;
    logic [2:0]           w_sel;
    logic                 w_found;
    logic [31:0]          w_addr;
    logic [NREQ-1:0]      w_onehot;

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner.
    always_comb begin
        w_dbl   = {pe_read, pe_read};
        w_rot   = NREQ'(w_dbl >> rr_ptr_q);
        w_off   = 3'd0;
        w_found = |pe_read;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = 3'(k);
            end
        end
        w_sum = {1'b0, rr_ptr_q} + {1'b0, w_off};
        w_sel = (w_sum >= 4'(NREQ)) ? 3'(w_sum - 4'(NREQ)) : w_sum[2:0];

        w_addr = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == w_sel) begin
                w_addr = pe_addr[i*32 +: 32];
            end
        end

        for (int i = 0; i < NREQ; i++) begin
            w_onehot[i] = (3'(i) == grant_id_q);
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        cnt_d         = cnt_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;
        pe_ack_d      = '0;
        pe_rdata_d    = pe_rdata_q;
        pe_err_d      = pe_err_q;

        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_id_d    = w_sel;
                    mem_address_d = w_addr;
                    mem_read_d    = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                // A late mem_ack still beats the timeout in the same cycle.
                if (mem_ack || (cnt_q == c_cnt_last)) begin
                    pe_rdata_d = mem_ack ? mem_Message : 32'd0;
                    pe_err_d   = ~mem_ack;
                    pe_ack_d   = w_onehot;
                    mem_read_d = 1'b0;
                    rr_ptr_d   = (grant_id_q == 3'(NREQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= 3'd0;
            grant_id_q    <= 3'd0;
            cnt_q         <= '0;
            mem_read_q    <= 1'b0;
            mem_address_q <= 32'd0;
            pe_ack_q      <= '0;
            pe_rdata_q    <= 32'd0;
            pe_err_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            cnt_q         <= cnt_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            pe_ack_q      <= pe_ack_d;
            pe_rdata_q    <= pe_rdata_d;
            pe_err_q      <= pe_err_d;
            busy_q        <= busy_d;
        end
    end

    assign pe_ack      = pe_ack_q;
    assign pe_rdata    = pe_rdata_q;
    assign pe_err      = pe_err_q;
    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;

endmodule
`default_nettype wire
